// File: rtl/m72_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Holds the arbiter state enum and the round-robin pick helper.
package m72_pkg;

    localparam int N_CLIENTS  = 3;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        DRAIN,
        IDLE,
        WAIT,
        ACK
    } arb_state_t;

    // Walk clients from last+1 upwards; the nearest requester wins.
    function automatic logic [1:0] rr_pick(
        input logic [N_CLIENTS-1:0] req,
        input logic [1:0]           last
    );
        logic [1:0] pick;
        logic [1:0] idx;
        int         t;
        pick = last;
        for (int k = N_CLIENTS; k >= 1; k--) begin
            t   = (int'(last) + k) % N_CLIENTS;
            idx = 2'(t);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync2.sv
// Single-bit multi-flop synchronizer for the SDRAM ack toggle.
// No reset: the chain just settles to the far-domain level.
module sync2
    import m72_pkg::*;
(
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] sr;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk) begin
        sr <= {sr[SYNC_DEPTH-2:0], d};
    end

    assign q = sr[SYNC_DEPTH-1];

endmodule

// File: rtl/sdr_port_arbiter.sv
// Three-client round-robin arbiter onto a toggle-protocol SDRAM channel.
// The channel is idle whenever the synchronized ack equals sdr_req.
module sdr_port_arbiter
    import m72_pkg::*;
(
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        c0_req,
    input  logic [24:1] c0_addr,
    input  logic [15:0] c0_din,
    input  logic [1:0]  c0_wr_sel,
    output logic [15:0] c0_dout,
    output logic        c0_ack,
    input  logic        c1_req,
    input  logic [24:1] c1_addr,
    input  logic [15:0] c1_din,
    input  logic [1:0]  c1_wr_sel,
    output logic [15:0] c1_dout,
    output logic        c1_ack,
    input  logic        c2_req,
    input  logic [24:1] c2_addr,
    input  logic [15:0] c2_din,
    input  logic [1:0]  c2_wr_sel,
    output logic [15:0] c2_dout,
    output logic        c2_ack,
    output logic [24:1] sdr_addr,
    output logic [15:0] sdr_din,
    output logic [1:0]  sdr_wr_sel,
    output logic        sdr_req,
    input  logic [15:0] sdr_dout,
    input  logic        sdr_ack
);

    logic [N_CLIENTS-1:0] req_v;
    logic [24:1]          addr_v [N_CLIENTS];
    logic [15:0]          din_v  [N_CLIENTS];
    logic [1:0]           wr_v   [N_CLIENTS];
    logic [15:0]          dout_q [N_CLIENTS];
    logic [N_CLIENTS-1:0] ack_q;

    arb_state_t state;
    arb_state_t state_nx;
    logic [1:0] last_grant;
    logic [1:0] cur;
    logic [1:0] pick;
    logic       ack_s;
    logic       chan_idle;
    logic       issue;
    logic       capture;
    logic       req_tgl = 1'b0;

    assign req_v     = {c2_req, c1_req, c0_req};
    assign addr_v[0] = c0_addr;
    assign addr_v[1] = c1_addr;
    assign addr_v[2] = c2_addr;
    assign din_v[0]  = c0_din;
    assign din_v[1]  = c1_din;
    assign din_v[2]  = c2_din;
    assign wr_v[0]   = c0_wr_sel;
    assign wr_v[1]   = c1_wr_sel;
    assign wr_v[2]   = c2_wr_sel;

    assign c0_dout = dout_q[0];
    assign c1_dout = dout_q[1];
    assign c2_dout = dout_q[2];
    assign c0_ack  = ack_q[0];
    assign c1_ack  = ack_q[1];
    assign c2_ack  = ack_q[2];
    assign sdr_req = req_tgl;

    sync2 u_ack_sync (
        .clk (CLK_32M),
        .d   (sdr_ack),
        .q   (ack_s)
    );

    assign chan_idle = (ack_s == req_tgl);
    assign pick      = rr_pick(req_v, last_grant);

    // State register; reset parks in DRAIN until the channel settles.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) state <= DRAIN;
        else          state <= state_nx;
    end

    // Next state plus the one-cycle issue/capture strobes.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        capture  = 1'b0;
        unique case (state)
            DRAIN: begin
                if (chan_idle) state_nx = IDLE;
            end
            IDLE: begin
                if ((|req_v) && chan_idle) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (chan_idle) begin
                    capture  = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: state_nx = DRAIN;
        endcase
    end

    // Grant bookkeeping, write enables, read data capture and acks.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            last_grant <= 2'(N_CLIENTS - 1);
            sdr_wr_sel <= 2'b00;
            ack_q      <= '0;
            for (int i = 0; i < N_CLIENTS; i++) dout_q[i] <= '0;
        end else begin
            ack_q <= '0;
            if (issue) begin
                last_grant <= pick;
                sdr_wr_sel <= wr_v[pick];
            end
            if (capture) begin
                dout_q[cur] <= sdr_dout;
                ack_q[cur]  <= 1'b1;
            end
        end
    end

    // Address, data and toggle survive reset so an access can drain.
    always_ff @(posedge CLK_32M) begin
        if (issue && reset_n) begin
            sdr_addr <= addr_v[pick];
            sdr_din  <= din_v[pick];
            cur      <= pick;
            req_tgl  <= ~req_tgl;
        end
    end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed bench for sdr_port_arbiter with a toggle-protocol SDRAM model.
// The model runs on a 3x faster clock with programmable ack latency.
module tb_sdr_port_arbiter;

    logic        CLK_32M = 1'b0;
    logic        clk_96  = 1'b0;
    logic        reset_n = 1'b0;
    logic        c0_req = 1'b0, c1_req = 1'b0, c2_req = 1'b0;
    logic [24:1] c0_addr = '0, c1_addr = '0, c2_addr = '0;
    logic [15:0] c0_din = '0, c1_din = '0, c2_din = '0;
    logic [1:0]  c0_wr_sel = '0, c1_wr_sel = '0, c2_wr_sel = '0;
    logic [15:0] c0_dout, c1_dout, c2_dout;
    logic        c0_ack, c1_ack, c2_ack;
    logic [24:1] sdr_addr;
    logic [15:0] sdr_din;
    logic [1:0]  sdr_wr_sel;
    logic        sdr_req;
    logic [15:0] sdr_dout = '0;
    logic        sdr_ack  = 1'b0;

    int checks = 0;
    int errors = 0;
    int toggles = 0;
    int lat = 5;
    int mcnt = 0;
    logic req_prev = 1'b0;

    logic [15:0]  mem [256];
    logic [255:0] mem_ok = '0;
    logic [7:0]   m_idx;
    logic [15:0]  m_word;
    logic [2:0]   acks;

    assign acks = {c2_ack, c1_ack, c0_ack};

    sdr_port_arbiter dut (
        .CLK_32M    (CLK_32M),
        .reset_n    (reset_n),
        .c0_req     (c0_req),
        .c0_addr    (c0_addr),
        .c0_din     (c0_din),
        .c0_wr_sel  (c0_wr_sel),
        .c0_dout    (c0_dout),
        .c0_ack     (c0_ack),
        .c1_req     (c1_req),
        .c1_addr    (c1_addr),
        .c1_din     (c1_din),
        .c1_wr_sel  (c1_wr_sel),
        .c1_dout    (c1_dout),
        .c1_ack     (c1_ack),
        .c2_req     (c2_req),
        .c2_addr    (c2_addr),
        .c2_din     (c2_din),
        .c2_wr_sel  (c2_wr_sel),
        .c2_dout    (c2_dout),
        .c2_ack     (c2_ack),
        .sdr_addr   (sdr_addr),
        .sdr_din    (sdr_din),
        .sdr_wr_sel (sdr_wr_sel),
        .sdr_req    (sdr_req),
        .sdr_dout   (sdr_dout),
        .sdr_ack    (sdr_ack)
    );

    always #15 CLK_32M = ~CLK_32M;
    always #5  clk_96  = ~clk_96;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h00:   return 16'hBEEF;
            8'h10:   return 16'h1111;
            8'h20:   return 16'h2222;
            8'h30:   return 16'h3333;
            8'h40:   return 16'hABCD;
            default: return {a, ~a};
        endcase
    endfunction

    assign m_idx  = sdr_addr[8:1];
    assign m_word = mem_ok[m_idx] ? mem[m_idx] : init_val(m_idx);

    // SDRAM side: answer each toggle after lat fast-clock cycles.
    always @(posedge clk_96) begin
        if (sdr_req !== sdr_ack) begin
            if (mcnt >= lat) begin
                if (sdr_wr_sel == 2'b00) begin
                    sdr_dout <= m_word;
                end else begin
                    mem[m_idx] <= {sdr_wr_sel[1] ? sdr_din[15:8] : m_word[15:8],
                                   sdr_wr_sel[0] ? sdr_din[7:0]  : m_word[7:0]};
                    mem_ok[m_idx] <= 1'b1;
                end
                sdr_ack <= sdr_req;
                mcnt    <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // Count request toggles as seen on the system clock.
    always @(posedge CLK_32M) begin
        if (sdr_req !== req_prev) toggles <= toggles + 1;
        req_prev <= sdr_req;
    end

    task automatic tick();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output logic [2:0] got,
                            output int n);
        got = 3'b000;
        n   = 0;
        while (got == 3'b000 && n < budget) begin
            tick();
            n++;
            got = {c2_ack, c1_ack, c0_ack};
        end
    endtask

    task automatic wait_toggle(input logic ref_v, output int n);
        n = 0;
        while (sdr_req === ref_v && n < 10) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [2:0] got;
        int         n;
        int         base;
        logic       snap;

        // reset values
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_acks", acks, 3'b000);
        chk("rst_c0_dout", c0_dout, 16'h0000);
        chk("rst_c1_dout", c1_dout, 16'h0000);
        chk("rst_c2_dout", c2_dout, 16'h0000);
        chk("rst_wr_sel", sdr_wr_sel, 2'b00);
        chk("rst_sdr_req", sdr_req, 1'b0);
        reset_n = 1'b1;
        tick();

        // single read by client 1
        base      = toggles;
        c1_addr   = 24'h000100;
        c1_wr_sel = 2'b00;
        c1_req    = 1'b1;
        wait_ack(40, got, n);
        c1_req = 1'b0;
        chk("rd_ack", got, 3'b010);
        chk("rd_lat_min", n >= 4, 1'b1);
        chk("rd_dout", c1_dout, 16'hBEEF);
        chk("rd_addr", sdr_addr, 24'h000100);
        tick();
        chk("rd_ack_pulse", acks, 3'b000);
        tick();
        chk("rd_toggles", toggles - base, 1);
        chk("rd_dout_hold", c1_dout, 16'hBEEF);

        // contention right after reset: order 0,1,2
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        base    = toggles;
        c0_addr = 24'h000010;
        c1_addr = 24'h000020;
        c2_addr = 24'h000030;
        c0_req  = 1'b1;
        c1_req  = 1'b1;
        c2_req  = 1'b1;
        wait_ack(40, got, n);
        c0_req = 1'b0;
        chk("ct_first", got, 3'b001);
        chk("ct_c0_dout", c0_dout, 16'h1111);
        wait_ack(40, got, n);
        c1_req = 1'b0;
        chk("ct_second", got, 3'b010);
        chk("ct_c1_dout", c1_dout, 16'h2222);
        wait_ack(40, got, n);
        c2_req = 1'b0;
        chk("ct_third", got, 3'b100);
        chk("ct_c2_dout", c2_dout, 16'h3333);
        tick();
        tick();
        chk("ct_toggles", toggles - base, 3);

        // high-byte write by client 2, others wiggle meanwhile
        c2_addr   = 24'h000040;
        c2_din    = 16'h1234;
        c2_wr_sel = 2'b10;
        c2_req    = 1'b1;
        snap      = sdr_req;
        wait_toggle(snap, n);
        chk("wr_issue", sdr_req, !snap);
        got = 3'b000;
        n   = 0;
        while (got == 3'b000 && n < 40) begin
            if (n == 0) begin
                c0_addr = 24'hFFFFFF;
                c0_din  = 16'hDEAD;
                c1_din  = 16'h5555;
            end
            if (sdr_ack !== sdr_req) begin
                chk("wr_sel_hold", sdr_wr_sel, 2'b10);
                chk("wr_din_hold", sdr_din, 16'h1234);
                chk("wr_addr_hold", sdr_addr, 24'h000040);
            end
            tick();
            n++;
            got = acks;
        end
        c2_req    = 1'b0;
        c2_wr_sel = 2'b00;
        chk("wr_ack", got, 3'b100);

        // read back the merged word through client 1
        c1_addr = 24'h000040;
        c1_req  = 1'b1;
        wait_ack(40, got, n);
        c1_req = 1'b0;
        chk("rb_ack", got, 3'b010);
        chk("rb_dout", c1_dout, 16'h12CD);

        // reset while an access is in flight
        lat     = 30;
        base    = toggles;
        c1_addr = 24'h000020;
        c1_req  = 1'b1;
        snap    = sdr_req;
        wait_toggle(snap, n);
        chk("rw_issue", sdr_req, !snap);
        tick();
        reset_n = 1'b0;
        c1_req  = 1'b0;
        repeat (3) begin
            tick();
            chk("rw_rst_acks", acks, 3'b000);
        end
        chk("rw_rst_dout", c1_dout, 16'h0000);
        reset_n = 1'b1;
        c0_addr = 24'h000010;
        c0_req  = 1'b1;
        c1_req  = 1'b1;
        snap    = sdr_req;
        n       = 0;
        while (sdr_ack !== sdr_req && n < 40) begin
            chk("rw_no_toggle", sdr_req, snap);
            chk("rw_no_ack", acks, 3'b000);
            tick();
            n++;
        end
        chk("rw_drained", n < 40, 1'b1);
        lat = 5;
        wait_ack(40, got, n);
        c0_req = 1'b0;
        chk("rw_first_c0", got, 3'b001);
        chk("rw_c0_dout", c0_dout, 16'h1111);
        wait_ack(40, got, n);
        c1_req = 1'b0;
        chk("rw_then_c1", got, 3'b010);
        chk("rw_c1_dout", c1_dout, 16'h2222);
        tick();
        tick();
        chk("rw_toggles", toggles - base, 3);

        // fairness: c0 keeps requesting, c2 arrives mid-access
        c0_req = 1'b1;
        snap   = sdr_req;
        wait_toggle(snap, n);
        c2_addr = 24'h000030;
        c2_req  = 1'b1;
        wait_ack(40, got, n);
        chk("fr_first_c0", got, 3'b001);
        wait_ack(40, got, n);
        c2_req = 1'b0;
        chk("fr_c2_next", got, 3'b100);
        chk("fr_c2_dout", c2_dout, 16'h3333);
        wait_ack(40, got, n);
        c0_req = 1'b0;
        chk("fr_c0_again", got, 3'b001);
        tick();
        tick();

        // back-to-back: c0 holds req through its ack
        base   = toggles;
        c0_req = 1'b1;
        wait_ack(40, got, n);
        chk("bb_first", got, 3'b001);
        snap = sdr_req;
        tick();
        chk("bb_idle_cycle", sdr_req, snap);
        tick();
        chk("bb_reissue", sdr_req, !snap);
        wait_ack(40, got, n);
        c0_req = 1'b0;
        chk("bb_second", got, 3'b001);
        tick();
        tick();
        chk("bb_toggles", toggles - base, 2);
        chk("bb_quiet", acks, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
